// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - step strobe generator and period-aligned linear duty ramp for the pwm block
module pwm_fade_ctrl #(
  parameter int N        = 8,
  parameter int STEP_DIV = 100,
  parameter int RATE_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N-1:0]      cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              abort,
  output logic              step,
  output logic [N-1:0]      duty,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0]       DIV_MAX = 16'(STEP_DIV - 1);
  localparam logic [N-1:0]      PER_MAX = '1;
  localparam logic [N-1:0]      ONE     = 1;
  localparam logic [RATE_W-1:0] RONE    = 1;

  typedef enum logic {IDLE, FADE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       div_cnt, div_nxt;
  logic [N-1:0]      per_cnt;
  logic [N-1:0]      tgt, tgt_nxt;
  logic [N-1:0]      duty_nxt, duty_step;
  logic [RATE_W-1:0] rate, rate_nxt;
  logic [RATE_W-1:0] rate_cnt, rate_cnt_nxt;
  logic              period_end;
  logic              done_nxt;

  assign div_nxt    = (div_cnt == DIV_MAX) ? 16'd0 : div_cnt + 16'd1;
  assign period_end = step & (per_cnt == PER_MAX);
  assign duty_step  = (tgt > duty) ? duty + ONE : duty - ONE;
  assign cmd_ready  = (state == IDLE);

  // step is registered from the next prescaler value so it lines up with div_cnt == STEP_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      step     <= 1'b0;
      per_cnt  <= '0;
      tgt      <= '0;
      rate     <= '0;
      rate_cnt <= '0;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      step    <= (div_nxt == DIV_MAX);
      if (step) begin
        per_cnt <= per_cnt + ONE;
      end
      state    <= state_nxt;
      tgt      <= tgt_nxt;
      rate     <= rate_nxt;
      rate_cnt <= rate_cnt_nxt;
      duty     <= duty_nxt;
      busy     <= (state_nxt == FADE);
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tgt_nxt      = tgt;
    rate_nxt     = rate;
    rate_cnt_nxt = rate_cnt;
    duty_nxt     = duty;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          tgt_nxt      = cmd_target;
          rate_nxt     = cmd_rate;
          rate_cnt_nxt = '0;
          if (cmd_target == duty) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = FADE;
          end
        end
      end
      FADE: begin
        // abort takes priority over a coincident period-boundary update
        if (abort) begin
          state_nxt    = IDLE;
          rate_cnt_nxt = '0;
        end else if (period_end) begin
          if (rate_cnt == rate) begin
            rate_cnt_nxt = '0;
            duty_nxt     = duty_step;
            if (duty_step == tgt) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            rate_cnt_nxt = rate_cnt + RONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
